// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher (InvCipher) for 128/192/256-bit keys.
// One round per clock. The precomputed round-key schedule is read in place:
// it is not captured, so it must stay stable while a block is in flight.
module aes_inv_cipher_iter #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          ciphertext,
  input  logic [0:128*(NR+1)-1] key_schedule,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          plaintext,
  output logic                  busy
);

  // Only the three FIPS-197 key sizes are supported.
  if (!((NK == 32'sd4 && NR == 32'sd10) ||
        (NK == 32'sd6 && NR == 32'sd12) ||
        (NK == 32'sd8 && NR == 32'sd14))) begin : g_bad_key_size
    $error("aes_inv_cipher_iter: illegal NK/NR pair");
  end

  localparam logic [3:0] LAST_ROUND_C  = 4'(NR - 32'sd1);
  localparam int         RK_LAST_OFS_C = 128 * NR;

  // Inverse S-box, byte b at bits [8*b +: 8] (row-major, 16 bytes per line).
  localparam logic [0:2047] INV_SBOX_C = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  fsm_t         fsm_r;
  logic [3:0]   round_r;
  logic [127:0] state_r;
  logic [127:0] plaintext_r;
  logic         out_valid_r;
  logic         in_ready_r;
  logic         busy_r;

  logic [127:0] rk_cur_s;
  logic [127:0] rk_last_s;
  logic [127:0] isr_s;
  logic [127:0] isb_s;
  logic [127:0] ark_s;
  logic [127:0] imc_s;

  // GF(2^8) multiply by x, reduced by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_C[{b, 3'b000} +: 8];
  endfunction

  // Row r is rotated right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
    end
    return o;
  endfunction

  // One column times the {0e,0b,0d,09} circulant matrix.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  // Round datapath; in FINAL round_r is 0, so ark_s already carries rk[0].
  always_comb begin
    rk_cur_s  = key_schedule[{round_r, 7'b0000000} +: 128];
    rk_last_s = key_schedule[RK_LAST_OFS_C +: 128];
    isr_s     = inv_shift_rows(state_r);
    isb_s     = inv_sub_bytes(isr_s);
    ark_s     = isb_s ^ rk_cur_s;
    imc_s     = inv_mix_columns(ark_s);
  end

  // Control FSM with the round state and all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r       <= IDLE;
      round_r     <= 4'd0;
      state_r     <= 128'h0;
      plaintext_r <= 128'h0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (in_valid) begin
            state_r    <= ciphertext ^ rk_last_s;
            round_r    <= LAST_ROUND_C;
            fsm_r      <= (LAST_ROUND_C == 4'd0) ? FINAL : ROUND;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ROUND: begin
          state_r <= imc_s;
          round_r <= round_r - 4'd1;
          if (round_r == 4'd1) begin
            fsm_r <= FINAL;
          end
        end
        FINAL: begin
          plaintext_r <= ark_s;
          out_valid_r <= 1'b1;
          fsm_r       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            fsm_r       <= IDLE;
          end
        end
        default: begin
          fsm_r       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign plaintext = plaintext_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 vectors for all three key
// sizes, latency, backpressure, mid-operation reset and back-to-back blocks.
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic         busy_a      [3];
  logic [127:0] ct_a        [3];
  logic [127:0] pt_a        [3];
  logic [0:1919] ks_a       [3];

  int checks = 0;
  int errors = 0;
  int acc0   = 0;

  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2_CT = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  // Forward S-box, used only to build round-key schedules in the bench.
  logic [0:2047] sbox_v = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_inv_cipher_iter #(.NK(4), .NR(10)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .ciphertext(ct_a[0]), .key_schedule(ks_a[0][0:1407]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .plaintext(pt_a[0]), .busy(busy_a[0]));

  aes_inv_cipher_iter #(.NK(6), .NR(12)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .ciphertext(ct_a[1]), .key_schedule(ks_a[1][0:1663]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .plaintext(pt_a[1]), .busy(busy_a[1]));

  aes_inv_cipher_iter #(.NK(8), .NR(14)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .ciphertext(ct_a[2]), .key_schedule(ks_a[2]), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]), .plaintext(pt_a[2]), .busy(busy_a[2]));

  // The schedule is read in place, so it must not move while a block is in flight.
  logic [0:1919] ks0_mon;
  logic          busy0_mon;
  assign ks0_mon   = ks_a[0];
  assign busy0_mon = busy_a[0];
  a_ks_stable: assert property (@(posedge clk) disable iff (!rst_n) busy0_mon |-> $stable(ks0_mon))
    else $error("key_schedule changed while block in flight");

  // Count handshakes accepted by the AES-128 instance.
  always @(posedge clk) begin
    if (rst_n && in_valid_a[0] && in_ready_a[0]) acc0 <= acc0 + 1;
  end

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[31 - 8*i -: 8] = sbox_v[{w[31 - 8*i -: 8], 3'b000} +: 8];
    return o;
  endfunction

  // FIPS-197 KeyExpansion; round key i lands at bits [128*i +: 128].
  function automatic logic [0:1919] expand_key(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] ks;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      ks[32*i +: 32] = w[i];
    end
    return ks;
  endfunction

  // Send one block (out_ready assumed high), check latency and result.
  // Latency counts edges from the accept edge (counted as 1) to out_valid rising.
  task automatic run_block(input int idx, input logic [127:0] ct, input logic [127:0] exp,
                           input int nr, input string tag);
    int lat;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready_a[idx]; i++) @(negedge clk);
    ct_a[idx]       = ct;
    in_valid_a[idx] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        in_valid_a[idx] = 1'b0;
        ct_a[idx]       = 128'hdeadbeef_0badf00d_cafebabe_12345678;
      end
    end while (!out_valid_a[idx] && lat < 40);
    check_val({tag, " latency"}, 128'(lat), 128'(nr + 1));
    check_val({tag, " plaintext"}, pt_a[idx], exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int acc_base;
    int cyc;
    int nout;
    int t_out [3];

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b1;
      ct_a[i]        = 128'h0;
      t_out[i]       = 0;
    end
    ks_a[0] = expand_key(KEY_B, 4);
    ks_a[1] = expand_key(KEY_C2, 6);
    ks_a[2] = expand_key(KEY_C3, 8);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst out_valid", 128'(out_valid_a[0]), 128'd0);
    check_val("rst in_ready", 128'(in_ready_a[0]), 128'd1);
    check_val("rst busy", 128'(busy_a[0]), 128'd0);
    check_val("rst plaintext", pt_a[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // AES-128, FIPS-197 Appendix B
    run_block(0, B_CT, B_PT, 10, "aes128 appB");

    // Backpressure: out_ready low for 5 cycles with in_valid held high
    acc_base = acc0;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    ct_a[0]        = B_CT;
    in_valid_a[0]  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid_a[0] && lat < 40);
    check_val("bp latency", 128'(lat), 128'd11);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("bp plaintext hold", pt_a[0], B_PT);
      check_val("bp in_ready low", 128'(in_ready_a[0]), 128'd0);
      check_val("bp out_valid hold", 128'(out_valid_a[0]), 128'd1);
    end
    check_val("bp single accept", 128'(acc0 - acc_base), 128'd1);
    @(negedge clk);
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp out_valid drop", 128'(out_valid_a[0]), 128'd0);
    check_val("bp idle in_ready", 128'(in_ready_a[0]), 128'd1);
    check_val("bp idle busy", 128'(busy_a[0]), 128'd0);
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    @(posedge clk);
    #1;
    check_val("bp next accept", 128'(acc0 - acc_base), 128'd2);
    check_val("bp next busy", 128'(busy_a[0]), 128'd1);
    in_valid_a[0] = 1'b0;
    lat = 1;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid_a[0] && lat < 40);
    check_val("bp2 latency", 128'(lat), 128'd11);
    check_val("bp2 plaintext", pt_a[0], B_PT);
    @(negedge clk);
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    #1;

    // AES-192 and AES-256, Appendix C.2 / C.3
    run_block(1, C2_CT, C_PT, 12, "aes192 appC2");
    run_block(2, C3_CT, C_PT, 14, "aes256 appC3");

    // Reset in the middle of round 5
    @(negedge clk);
    ct_a[0]       = B_CT;
    in_valid_a[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("midrst busy before", 128'(busy_a[0]), 128'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst out_valid", 128'(out_valid_a[0]), 128'd0);
    check_val("midrst plaintext", pt_a[0], 128'h0);
    check_val("midrst in_ready", 128'(in_ready_a[0]), 128'd1);
    check_val("midrst busy", 128'(busy_a[0]), 128'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    ks_a[0] = expand_key(KEY_C1, 4);
    run_block(0, C1_CT, C_PT, 10, "aes128 appC1 after reset");

    // Back-to-back: in_valid held high, out_ready tied high, three blocks
    acc_base = acc0;
    @(negedge clk);
    ct_a[0]       = C1_CT;
    in_valid_a[0] = 1'b1;
    cyc  = 0;
    nout = 0;
    while (nout < 3 && cyc < 80) begin
      @(posedge clk);
      cyc++;
      #1;
      if (acc0 - acc_base >= 3) in_valid_a[0] = 1'b0;
      if (out_valid_a[0]) begin
        check_val("b2b plaintext", pt_a[0], C_PT);
        t_out[nout] = cyc;
        nout++;
      end
    end
    in_valid_a[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("b2b outputs", 128'(nout), 128'd3);
    check_val("b2b accepts", 128'(acc0 - acc_base), 128'd3);
    // Spacing counted inclusively of both output edges, like the latency.
    check_val("b2b spacing 1", 128'(t_out[1] - t_out[0] + 1), 128'd13);
    check_val("b2b spacing 2", 128'(t_out[2] - t_out[1] + 1), 128'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
